// File: rtl/mac_params.sv
// ---------------------------------------------------------------------------
// mac_params
// Shared MAC-level constants and types.
//   N_SYMBOLS     : bytes carried per AXI-Stream beat
//   W_SYMBOL      : bits per byte
//   RX_BUF_DEPTH  : default depth (in beats) of the RX frame buffer
//   rx_buf_word_t : one buffer word, {tlast, tkeep, tdata}
//   rx_wr_state_e : write-side FSM states of the RX frame buffer
// ---------------------------------------------------------------------------
package mac_params;

    localparam int N_SYMBOLS    = 8;
    localparam int W_SYMBOL     = 8;
    localparam int RX_BUF_DEPTH = 512;

    typedef struct packed {
        logic                            tlast;
        logic [N_SYMBOLS-1:0]            tkeep;
        logic [N_SYMBOLS*W_SYMBOL-1:0]   tdata;
    } rx_buf_word_t;

    typedef enum logic {
        RECV = 1'b0,
        DROP = 1'b1
    } rx_wr_state_e;

endpackage

// File: rtl/sdp_ram.sv
// ---------------------------------------------------------------------------
// sdp_ram
// Simple dual-port RAM, one clock, registered read (latency 1).
//   clk     : clock
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable; rd_data only changes when this is high
//   rd_addr : read address
//   rd_data : registered read data
// ---------------------------------------------------------------------------
module sdp_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // The read register holds its value while rd_en is low, which the
    // downstream output stage relies on to park a prefetched word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_axis_frame_buffer.sv
// ---------------------------------------------------------------------------
// rx_axis_frame_buffer
// Store-and-forward RX frame buffer behind the MAC RX stream (no tready on
// the input). Only frames ending with tlast && !tuser that fit in the buffer
// are released to the backpressure-capable output stream.
//   i_rx_clk, i_rx_reset         : clock, async active-low reset
//   s_axis_*                     : input beats from the MAC (always accepted)
//   m_axis_*                     : output stream to user logic
//   o_overflow                   : one-cycle pulse per overflow drop
//   o_frames_ok/_drop_err/_drop_ovf : wrapping statistics counters
// ---------------------------------------------------------------------------
module rx_axis_frame_buffer
    import mac_params::*;
#(
    parameter int DEPTH = RX_BUF_DEPTH,
    parameter int W_CNT = 32
) (
    input  logic                          i_rx_clk,
    input  logic                          i_rx_reset,
    input  logic                          s_axis_tvalid,
    input  logic [N_SYMBOLS*W_SYMBOL-1:0] s_axis_tdata,
    input  logic [N_SYMBOLS-1:0]          s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tuser,
    output logic                          m_axis_tvalid,
    output logic [N_SYMBOLS*W_SYMBOL-1:0] m_axis_tdata,
    output logic [N_SYMBOLS-1:0]          m_axis_tkeep,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          o_overflow,
    output logic [W_CNT-1:0]              o_frames_ok,
    output logic [W_CNT-1:0]              o_frames_drop_err,
    output logic [W_CNT-1:0]              o_frames_drop_ovf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int WORD_W = $bits(rx_buf_word_t);

    rx_wr_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W_CNT-1:0] ok_cnt_q, ok_cnt_d;
    logic [W_CNT-1:0] err_cnt_q, err_cnt_d;
    logic [W_CNT-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             overflow_q, overflow_d;
    logic             s1_valid_q, s1_valid_d;
    logic             out_valid_q, out_valid_d;
    rx_buf_word_t     out_word_q, out_word_d;

    logic             full;
    logic             ram_wr_en;
    logic             ram_rd_en;
    logic             data_avail;
    logic             out_ready;
    logic             s1_move;
    rx_buf_word_t     wr_word;
    rx_buf_word_t     rd_word;

    assign wr_word = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    // Full uses rd_ptr before this cycle's read, so a slot freed by a read
    // in the same cycle is only reused from the next cycle on.
    assign full = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);

    sdp_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (i_rx_clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (wr_word),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    // Write FSM: a frame is committed on a good tlast; an errored or
    // overflowed frame rewinds wr_ptr back to the last commit point.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ok_cnt_d     = ok_cnt_q;
        err_cnt_d    = err_cnt_q;
        ovf_cnt_d    = ovf_cnt_q;
        overflow_d   = 1'b0;
        ram_wr_en    = 1'b0;
        if (s_axis_tvalid) begin
            case (state_q)
                RECV: begin
                    if (!full) begin
                        ram_wr_en = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                        if (s_axis_tlast && !s_axis_tuser) begin
                            commit_ptr_d = wr_ptr_q + PTR_W'(1);
                            ok_cnt_d     = ok_cnt_q + W_CNT'(1);
                        end else if (s_axis_tlast) begin
                            wr_ptr_d  = commit_ptr_q;
                            err_cnt_d = err_cnt_q + W_CNT'(1);
                        end
                    end else if (s_axis_tlast) begin
                        wr_ptr_d   = commit_ptr_q;
                        overflow_d = 1'b1;
                        ovf_cnt_d  = ovf_cnt_q + W_CNT'(1);
                    end else begin
                        state_d = DROP;
                    end
                end
                DROP: begin
                    // tuser is deliberately ignored: this frame is already
                    // lost to overflow and counts only as such.
                    if (s_axis_tlast) begin
                        wr_ptr_d   = commit_ptr_q;
                        overflow_d = 1'b1;
                        ovf_cnt_d  = ovf_cnt_q + W_CNT'(1);
                        state_d    = RECV;
                    end
                end
                default: state_d = RECV;
            endcase
        end
    end

    // Read side: RAM read register (stage 1) feeds the output register.
    // A new RAM read is issued only when stage 1 is empty or moving on,
    // so the RAM read register doubles as the skid slot.
    always_comb begin
        data_avail  = (rd_ptr_q != commit_ptr_q);
        out_ready   = !out_valid_q || m_axis_tready;
        s1_move     = s1_valid_q && out_ready;
        ram_rd_en   = data_avail && (!s1_valid_q || s1_move);
        rd_ptr_d    = ram_rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        s1_valid_d  = ram_rd_en || (s1_valid_q && !s1_move);
        out_valid_d = s1_move || (out_valid_q && !m_axis_tready);
        out_word_d  = s1_move ? rd_word : out_word_q;
    end

    always_ff @(posedge i_rx_clk or negedge i_rx_reset) begin
        if (!i_rx_reset) begin
            state_q      <= RECV;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            ok_cnt_q     <= '0;
            err_cnt_q    <= '0;
            ovf_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ok_cnt_q     <= ok_cnt_d;
            err_cnt_q    <= err_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
            overflow_q   <= overflow_d;
            s1_valid_q   <= s1_valid_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
        end
    end

    assign m_axis_tvalid     = out_valid_q;
    assign m_axis_tdata      = out_word_q.tdata;
    assign m_axis_tkeep      = out_word_q.tkeep;
    assign m_axis_tlast      = out_word_q.tlast;
    assign o_overflow        = overflow_q;
    assign o_frames_ok       = ok_cnt_q;
    assign o_frames_drop_err = err_cnt_q;
    assign o_frames_drop_ovf = ovf_cnt_q;

endmodule

// File: tb/tb_rx_axis_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_rx_axis_frame_buffer
// Scenario-driven bench for rx_axis_frame_buffer with DEPTH=16. A frame-level
// model decides each frame's fate (fits and good -> released, errored ->
// dropped, larger than free space -> overflow) and queues expected beats.
// ---------------------------------------------------------------------------
module tb_rx_axis_frame_buffer;
    import mac_params::*;

    localparam int DEPTH  = 16;
    localparam int W_CNT  = 32;
    localparam int W_DATA = N_SYMBOLS * W_SYMBOL;

    typedef struct packed {
        logic [W_DATA-1:0]    data;
        logic [N_SYMBOLS-1:0] keep;
        logic                 last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_axis_tvalid = 1'b0;
    logic [W_DATA-1:0]    s_axis_tdata = '0;
    logic [N_SYMBOLS-1:0] s_axis_tkeep = '0;
    logic                 s_axis_tlast = 1'b0;
    logic                 s_axis_tuser = 1'b0;
    logic                 m_axis_tvalid;
    logic [W_DATA-1:0]    m_axis_tdata;
    logic [N_SYMBOLS-1:0] m_axis_tkeep;
    logic                 m_axis_tlast;
    logic                 m_axis_tready = 1'b0;
    logic                 o_overflow;
    logic [W_CNT-1:0]     o_frames_ok;
    logic [W_CNT-1:0]     o_frames_drop_err;
    logic [W_CNT-1:0]     o_frames_drop_ovf;

    int checks = 0;
    int errors = 0;
    int exp_ok = 0;
    int exp_err = 0;
    int exp_ovf = 0;
    int tlast_seen = 0;
    int beats_seen = 0;
    int stalls_seen = 0;
    int ovf_pulses = 0;
    int ready_mode = 0;
    bit finished = 1'b0;

    beat_t exp_q[$];
    beat_t frm[$];

    rx_axis_frame_buffer #(
        .DEPTH (DEPTH),
        .W_CNT (W_CNT)
    ) dut (
        .i_rx_clk          (clk),
        .i_rx_reset        (rst_n),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tuser      (s_axis_tuser),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tkeep      (m_axis_tkeep),
        .m_axis_tlast      (m_axis_tlast),
        .m_axis_tready     (m_axis_tready),
        .o_overflow        (o_overflow),
        .o_frames_ok       (o_frames_ok),
        .o_frames_drop_err (o_frames_drop_err),
        .o_frames_drop_ovf (o_frames_drop_ovf)
    );

    always #5 clk = ~clk;

    // tready pattern generator: 0 = held low, 1 = held high,
    // 2 = random (~70% high), 3 = toggle every cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                2:       m_axis_tready = ($urandom_range(0, 9) < 7);
                3:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    // Output monitor: every transfer must match the model queue head, and a
    // stalled beat must stay put until it is taken.
    initial begin
        bit    stall_prev;
        beat_t prev;
        beat_t got;
        beat_t want;
        stall_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
                if (stall_prev) begin
                    checks++;
                    stalls_seen++;
                    if (m_axis_tvalid !== 1'b1 || got !== prev) begin
                        errors++;
                        $display("[TB] FAIL stall_hold got valid=%b beat=%h exp valid=1 beat=%h",
                                 m_axis_tvalid, got, prev);
                    end
                end
                if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                    checks++;
                    beats_seen++;
                    if (m_axis_tlast === 1'b1) tlast_seen++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_beat got %h exp none", got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("[TB] FAIL out_beat got %h exp %h", got, want);
                        end
                    end
                end
                stall_prev = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
                prev = got;
                if (o_overflow === 1'b1) ovf_pulses++;
            end
        end
    end

    task automatic build_random_frame(input int len);
        beat_t b;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            b.data = W_DATA'({$urandom(), $urandom()});
            b.last = (i == len - 1);
            b.keep = b.last ? N_SYMBOLS'($urandom_range(1, (1 << N_SYMBOLS) - 1)) : '1;
            frm.push_back(b);
        end
    endtask

    // Beat i of the frame carries byte value 0x11*(i+1) in every lane.
    task automatic build_pattern_frame(input int len, input logic [N_SYMBOLS-1:0] last_keep);
        beat_t               b;
        logic [W_SYMBOL-1:0] sym;
        frm.delete();
        for (int i = 0; i < len; i++) begin
            sym    = W_SYMBOL'(8'h11 * (i + 1));
            b.data = {N_SYMBOLS{sym}};
            b.last = (i == len - 1);
            b.keep = b.last ? last_keep : '1;
            frm.push_back(b);
        end
    endtask

    // Drives frm[] (optionally with idle gaps) and applies the frame model:
    // it overflows if longer than the free space the model knows of.
    task automatic send_frame(input bit tuser, input int gap_pct);
        int space;
        space = DEPTH - exp_q.size();
        for (int i = 0; i < frm.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = frm[i].data;
            s_axis_tkeep  = frm[i].keep;
            s_axis_tlast  = frm[i].last;
            s_axis_tuser  = frm[i].last ? tuser : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (frm.size() > space) begin
            exp_ovf++;
        end else if (tuser) begin
            exp_err++;
        end else begin
            exp_ok++;
            foreach (frm[i]) exp_q.push_back(frm[i]);
        end
    endtask

    task automatic wait_drain(input int budget, output bit drained);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        drained = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, o_overflow} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got valid=%b data=%h keep=%h last=%b ovf=%b exp all 0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, o_overflow);
        end
        checks++;
        if ({o_frames_ok, o_frames_drop_err, o_frames_drop_ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counters got %0d/%0d/%0d exp 0/0/0",
                     o_frames_ok, o_frames_drop_err, o_frames_drop_ovf);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        logic [2:0] tv;
        bit         drained;
        ready_mode = 1;
        @(posedge clk);
        #1;
        build_pattern_frame(3, N_SYMBOLS'(8'h0F));
        send_frame(1'b0, 0);
        tv[2] = m_axis_tvalid;
        @(posedge clk);
        #1;
        tv[1] = m_axis_tvalid;
        @(posedge clk);
        #1;
        tv[0] = m_axis_tvalid;
        checks++;
        if (tv !== 3'b001) begin
            errors++;
            $display("[TB] FAIL latency got tvalid after k,k+1,k+2 = %b exp 001", tv);
        end
        wait_drain(50, drained);
        checks++;
        if (!drained || o_frames_ok !== W_CNT'(exp_ok)) begin
            errors++;
            $display("[TB] FAIL good_frame got left=%0d ok=%0d exp left=0 ok=%0d",
                     exp_q.size(), o_frames_ok, exp_ok);
        end
    endtask

    task automatic test_error_drop();
        bit drained;
        build_random_frame(4);
        send_frame(1'b1, 0);
        build_random_frame(2);
        send_frame(1'b0, 0);
        wait_drain(50, drained);
        checks++;
        if (!drained || o_frames_drop_err !== W_CNT'(exp_err) || o_frames_ok !== W_CNT'(exp_ok)) begin
            errors++;
            $display("[TB] FAIL error_drop got left=%0d err=%0d ok=%0d exp left=0 err=%0d ok=%0d",
                     exp_q.size(), o_frames_drop_err, o_frames_ok, exp_err, exp_ok);
        end
    endtask

    task automatic test_overflow();
        int pulses0;
        bit drained;
        pulses0 = ovf_pulses;
        ready_mode = 0;
        @(posedge clk);
        #1;
        build_random_frame(20);
        send_frame(1'b0, 0);
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_pulse_at_tlast got %b exp 1", o_overflow);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || o_frames_drop_ovf !== W_CNT'(exp_ovf)) begin
            errors++;
            $display("[TB] FAIL ovf_drop got tvalid=%b ovf_cnt=%0d exp tvalid=0 ovf_cnt=%0d",
                     m_axis_tvalid, o_frames_drop_ovf, exp_ovf);
        end
        build_random_frame(4);
        send_frame(1'b0, 0);
        ready_mode = 1;
        wait_drain(50, drained);
        checks++;
        if (!drained || (ovf_pulses - pulses0) != 1 || o_frames_ok !== W_CNT'(exp_ok)) begin
            errors++;
            $display("[TB] FAIL ovf_recover got left=%0d pulses=%0d ok=%0d exp left=0 pulses=1 ok=%0d",
                     exp_q.size(), ovf_pulses - pulses0, o_frames_ok, exp_ok);
        end
    endtask

    task automatic test_exact_full();
        int beats;
        int gaps;
        bit started;
        bit drained;
        ready_mode = 0;
        @(posedge clk);
        #1;
        build_random_frame(DEPTH);
        send_frame(1'b0, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (o_frames_drop_ovf !== W_CNT'(exp_ovf) || o_frames_ok !== W_CNT'(exp_ok) || m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exact_full_accept got ovf=%0d ok=%0d tvalid=%b exp ovf=%0d ok=%0d tvalid=1",
                     o_frames_drop_ovf, o_frames_ok, m_axis_tvalid, exp_ovf, exp_ok);
        end
        ready_mode = 1;
        beats = 0;
        gaps = 0;
        started = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                started = 1'b1;
                beats++;
                if (m_axis_tlast === 1'b1) break;
            end else if (started) begin
                gaps++;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (beats != DEPTH || gaps != 0) begin
            errors++;
            $display("[TB] FAIL exact_full_stream got beats=%0d gaps=%0d exp beats=%0d gaps=0",
                     beats, gaps, DEPTH);
        end
        wait_drain(50, drained);
        checks++;
        if (!drained) begin
            errors++;
            $display("[TB] FAIL exact_full_drain got left=%0d exp 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int tl0;
        int b0;
        int s0;
        bit drained;
        tl0 = tlast_seen;
        b0 = beats_seen;
        s0 = stalls_seen;
        ready_mode = 3;
        build_random_frame(5);
        send_frame(1'b0, 0);
        build_random_frame(5);
        send_frame(1'b0, 0);
        wait_drain(100, drained);
        checks++;
        if (!drained || (beats_seen - b0) != 10 || (tlast_seen - tl0) != 2) begin
            errors++;
            $display("[TB] FAIL back_to_back got left=%0d beats=%0d tlast=%0d exp left=0 beats=10 tlast=2",
                     exp_q.size(), beats_seen - b0, tlast_seen - tl0);
        end
        checks++;
        if ((stalls_seen - s0) == 0) begin
            errors++;
            $display("[TB] FAIL back_to_back_stalls got %0d exp >0", stalls_seen - s0);
        end
        ready_mode = 1;
    endtask

    task automatic test_random();
        int len;
        int n;
        bit drained;
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 8);
            n = 0;
            while (exp_q.size() + len > DEPTH && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (exp_q.size() + len > DEPTH) begin
                checks++;
                errors++;
                $display("[TB] FAIL random_space_wait got queued=%0d exp <=%0d", exp_q.size(), DEPTH - len);
            end
            build_random_frame(len);
            send_frame(($urandom_range(0, 3) == 0), 20);
        end
        ready_mode = 1;
        wait_drain(200, drained);
        checks++;
        if (!drained || o_frames_ok !== W_CNT'(exp_ok) || o_frames_drop_err !== W_CNT'(exp_err)
            || o_frames_drop_ovf !== W_CNT'(exp_ovf)) begin
            errors++;
            $display("[TB] FAIL random_counters got left=%0d %0d/%0d/%0d exp left=0 %0d/%0d/%0d",
                     exp_q.size(), o_frames_ok, o_frames_drop_err, o_frames_drop_ovf,
                     exp_ok, exp_err, exp_ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit drained;
        ready_mode = 0;
        @(posedge clk);
        #1;
        build_random_frame(2);
        send_frame(1'b0, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || o_frames_ok === '0) begin
            errors++;
            $display("[TB] FAIL pre_reset_state got tvalid=%b ok=%0d exp tvalid=1 ok>0",
                     m_axis_tvalid, o_frames_ok);
        end
        build_random_frame(3);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = frm[0].data;
        s_axis_tkeep  = frm[0].keep;
        s_axis_tlast  = 1'b0;
        @(posedge clk);
        #1;
        s_axis_tdata = frm[1].data;
        s_axis_tkeep = frm[1].keep;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, o_overflow} !== '0
            || {o_frames_ok, o_frames_drop_err, o_frames_drop_ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset got valid=%b data=%h cnt=%0d/%0d/%0d exp all 0",
                     m_axis_tvalid, m_axis_tdata, o_frames_ok, o_frames_drop_err, o_frames_drop_ovf);
        end
        exp_q.delete();
        exp_ok = 0;
        exp_err = 0;
        exp_ovf = 0;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;
        build_random_frame(3);
        send_frame(1'b0, 0);
        wait_drain(50, drained);
        checks++;
        if (!drained || o_frames_ok !== W_CNT'(1) || o_frames_drop_err !== '0 || o_frames_drop_ovf !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset_frame got left=%0d %0d/%0d/%0d exp left=0 1/0/0",
                     exp_q.size(), o_frames_ok, o_frames_drop_err, o_frames_drop_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_error_drop();
        test_overflow();
        test_exact_full();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        finished = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL watchdog got timeout exp completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule

// File: doc/rx_axis_frame_buffer.md
Name: rx_axis_frame_buffer

Overview:
Store-and-forward RX frame buffer that sits directly downstream of the MAC/PCS RX AXI-Stream master. The MAC output has no tready, so this block accepts every input beat. It commits a frame only when the frame ends good (tlast with tuser=0 and no overflow). Errored or overflowed frames are rewound and never appear on the output, which is a backpressure-capable AXI-Stream master for the user logic.

Parameters:
DEPTH, 512, buffer depth in beats; power of two, minimum 16.
W_CNT, 32, width of the statistics counters.
N_SYMBOLS, from mac_params, bytes per beat.
W_SYMBOL, from mac_params, bits per byte.

Ports:
i_rx_clk  in  1  RX clock; the only clock in the block.
i_rx_reset  in  1  reset, asynchronous assert, active-low (0 = reset).
s_axis_tvalid  in  1  beat valid from MAC RX.
s_axis_tdata  in  N_SYMBOLS*W_SYMBOL  beat data.
s_axis_tkeep  in  N_SYMBOLS  byte enables.
s_axis_tlast  in  1  last beat of frame.
s_axis_tuser  in  1  frame error (bad FCS/code); sampled only with tlast.
m_axis_tvalid  out  1  output beat valid.
m_axis_tdata  out  N_SYMBOLS*W_SYMBOL  output data.
m_axis_tkeep  out  N_SYMBOLS  output byte enables.
m_axis_tlast  out  1  output last beat.
m_axis_tready  in  1  user ready.
o_overflow  out  1  one-cycle pulse when a frame is dropped for overflow.
o_frames_ok  out  W_CNT  count of committed frames; wraps.
o_frames_drop_err  out  W_CNT  count of frames dropped on tuser; wraps.
o_frames_drop_ovf  out  W_CNT  count of frames dropped on overflow; wraps.

Behaviour:
- Reset (i_rx_reset=0), asynchronous:
  - All pointers, counters and the drop flag clear to 0.
  - m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, o_overflow=0.
  - Any partially received frame is discarded.
- Storage: each word holds {tlast, tkeep, tdata}.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each log2(DEPTH)+1 bits. The MSB distinguishes full from empty.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - Readable data exists when rd_ptr != commit_ptr.
- Write FSM, states RECV and DROP:
  - RECV, beat with !full:
    - Write the beat and increment wr_ptr.
    - If tlast && !tuser: commit_ptr <= wr_ptr+1; o_frames_ok++.
    - If tlast && tuser: wr_ptr <= commit_ptr (rewind); o_frames_drop_err++.
  - RECV, beat while full:
    - Do not write.
    - If tlast: rewind, pulse o_overflow, o_frames_drop_ovf++, stay in RECV.
    - Otherwise go to DROP.
  - DROP: discard beats. On the tlast beat: rewind, pulse o_overflow, o_frames_drop_ovf++, return to RECV. tuser is ignored in DROP; an overflow drop counts only as overflow.
  - A single-beat frame (tlast on the first beat) is handled identically.
  - A frame longer than DEPTH is always dropped as overflow.
- Read side:
  - The RAM has registered read, latency 1. It feeds an output register stage (skid/prefetch) so that:
    - Consecutive committed beats stream with no bubbles while tready=1.
    - No beat is lost or duplicated under any tready pattern.
  - A transfer occurs when tvalid && tready.
  - While tvalid=1 && tready=0, tdata/tkeep/tlast hold stable.
  - The read side never reads past commit_ptr. A rewind therefore never affects data already in flight on the output.
- Latency: with the buffer empty and tready=1, the good tlast beat sampled at edge k gives m_axis_tvalid=1 for the frame's first beat after edge k+2.
- Simultaneous events:
  - A read and a write in the same cycle are both honoured.
  - full is evaluated from rd_ptr before that cycle's read; the conservative choice is required.
  - A commit and a read in the same cycle are both honoured.
- s_axis_tvalid=0 cycles inside a frame are permitted and ignored.

Decomposition:
- mac_params supplies N_SYMBOLS and W_SYMBOL.
- Add to mac_params:
  - RX_BUF_DEPTH (default 512).
  - The typedef rx_buf_word_t = struct packed {tlast, tkeep, tdata}.
  - The write-FSM enum {RECV, DROP}.
- One sub-module: sdp_ram, a simple dual-port RAM with parameters WIDTH and DEPTH, a single clock, and registered read.

Test Plan:
1. DEPTH=16, tready=1; 3-beat good frame, data 0x1111.., 0x2222.., 0x3333.., last tkeep 0x0F -> three identical beats out, tlast on beat 3 with tkeep 0x0F, tvalid first high 2 edges after the tlast edge; o_frames_ok=1.
2. 4-beat frame with tuser=1 on tlast, then a 2-beat good frame -> only the 2-beat frame appears; o_frames_drop_err=1, o_frames_ok=1.
3. DEPTH=16, tready=0; 20-beat frame -> o_overflow pulses once at its tlast, o_frames_drop_ovf=1, no output. Then a 4-beat good frame and tready=1 -> exactly those 4 beats out.
4. DEPTH=16, tready=0; exactly 16-beat good frame -> accepted with no overflow. After tready=1, all 16 beats stream contiguously with no gaps.
5. Two back-to-back 5-beat good frames, tready toggling 1,0,1,0 -> output order 10 beats intact, data stable on every stalled cycle, 2 tlast beats.
6. Assert i_rx_reset=0 mid-way through beat 2 of a frame -> outputs 0 immediately and counters 0. After release, a 3-beat good frame passes and o_frames_ok=1.
